// File: rtl/mux_2to1.sv
// Registered 2:1 operand selector: broadcast scalar A to every lane, or pass vector B.
// Optional per-lane write mask is enabled by defining MUX_2TO1_LANE_MASK_EN.
module mux_2to1 #(
    parameter int LANE_W = 32,
    parameter int LANES  = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [LANE_W-1:0]       A,
    input  logic [LANE_W*LANES-1:0] B,
    input  logic                    sel,
    input  logic                    in_valid,
`ifdef MUX_2TO1_LANE_MASK_EN
    input  logic [LANES-1:0]        lane_en,
`endif
    output logic [LANE_W*LANES-1:0] C,
    output logic                    out_valid
);

    localparam int VEC_W = LANE_W * LANES;

    if (LANE_W < 1 || LANES < 1) begin : g_bad_param
        $error("mux_2to1: LANE_W and LANES must both be at least 1");
    end

    logic [LANES-1:0] w_lane_en;
    logic [VEC_W-1:0] w_sel_data;
    logic [VEC_W-1:0] w_next_c;
    logic [VEC_W-1:0] r_c;
    logic             r_valid;

`ifdef MUX_2TO1_LANE_MASK_EN
    assign w_lane_en = lane_en;
`else
    assign w_lane_en = '1;
`endif

    // An unknown sel falls into the default arm, so C is cleared rather than guessed.
    always_comb begin
        w_sel_data = '0;
        case (sel)
            1'b0:    w_sel_data = {LANES{A}};
            1'b1:    w_sel_data = B;
            default: w_sel_data = '0;
        endcase
    end

    always_comb begin
        w_next_c = '0;
        for (int i = 0; i < LANES; i++) begin
            if (w_lane_en[i]) begin
                w_next_c[i*LANE_W +: LANE_W] = w_sel_data[i*LANE_W +: LANE_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c     <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_c <= w_next_c;
            end
        end
    end

    assign C         = r_c;
    assign out_valid = r_valid;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n && in_valid) begin
            assert (!$isunknown(sel))
            else $error("mux_2to1: sel is X/Z while in_valid is high");
        end
    end
`endif

endmodule

// File: tb/tb_mux_2to1.sv
// Scoreboard bench for mux_2to1: the driver queues expected C per valid input,
// a negedge monitor pops and compares on out_valid and checks that C holds otherwise.
module tb_mux_2to1;

    localparam int LANE_W = 32;
    localparam int LANES  = 6;
    localparam int VEC_W  = LANE_W * LANES;

    logic              clk;
    logic              rst_n;
    logic [LANE_W-1:0] A;
    logic [VEC_W-1:0]  B;
    logic              sel;
    logic              in_valid;
    logic [LANES-1:0]  lane_en;
    logic [VEC_W-1:0]  C;
    logic              out_valid;

    logic [VEC_W-1:0]  exp_q[$];
    logic [VEC_W-1:0]  model_c;
    logic              mon_en;
    int                n_checks;
    int                n_errors;

    mux_2to1 #(.LANE_W(LANE_W), .LANES(LANES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (A),
        .B         (B),
        .sel       (sel),
        .in_valid  (in_valid),
`ifdef MUX_2TO1_LANE_MASK_EN
        .lane_en   (lane_en),
`endif
        .C         (C),
        .out_valid (out_valid)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [VEC_W-1:0] act,
                         input logic [VEC_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Driver: inputs change on the falling edge, expected result queued when valid.
    task automatic drive(input logic v, input logic s, input logic [LANE_W-1:0] a,
                         input logic [VEC_W-1:0] b, input logic [LANES-1:0] m,
                         input logic [VEC_W-1:0] exp);
        @(negedge clk);
        in_valid = v;
        sel      = s;
        A        = a;
        B        = b;
        lane_en  = m;
        if (v) exp_q.push_back(exp);
    endtask

    // Monitor
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (out_valid) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_valid: got out_valid=1 expected empty scoreboard");
                end else begin
                    model_c = exp_q.pop_front();
                    check("result_c", C, model_c);
                end
            end else begin
                check("hold_c", C, model_c);
            end
        end
    end

    logic [VEC_W-1:0] b_ramp;
    logic [VEC_W-1:0] b_dist;
    logic [VEC_W-1:0] exp_mask;

    initial begin
        n_checks = 0;
        n_errors = 0;
        mon_en   = 1'b0;
        model_c  = '0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        sel      = 1'b0;
        A        = '0;
        B        = '0;
        lane_en  = '1;

        b_ramp = {32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0};
        b_dist = {32'h66666666, 32'h55555555, 32'h44444444,
                  32'h33333333, 32'h22222222, 32'h11111111};
`ifdef MUX_2TO1_LANE_MASK_EN
        exp_mask = {32'd5, 32'd0, 32'd3, 32'd0, 32'd1, 32'd0};
`else
        exp_mask = b_ramp;
`endif

        // Reset held with toggling valid inputs: outputs must stay cleared.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            sel      = i[0];
            A        = $urandom_range(32'hFFFF, 1);
            B        = b_dist;
            check("reset_c", C, '0);
            check("reset_valid", {{(VEC_W-1){1'b0}}, out_valid}, '0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        mon_en   = 1'b1;
        repeat (2) @(negedge clk);

        // Broadcast, pass-through, back-to-back, distinct lanes.
        drive(1'b1, 1'b0, 32'hF0F0F0F0, {6{32'h80000001}}, '1, {6{32'hF0F0F0F0}});
        drive(1'b1, 1'b1, 32'hF0F0F0F0, {6{32'h80000001}}, '1, {6{32'h80000001}});
        drive(1'b1, 1'b1, 32'h0,        b_dist,            '1, b_dist);
        drive(1'b1, 1'b0, 32'h12345678, b_dist,            '1, {6{32'h12345678}});
        // Hold: invalid cycles with changing sel and data.
        drive(1'b0, 1'b1, 32'hDEADBEEF, b_ramp,            '1, '0);
        drive(1'b0, 1'b0, 32'hCAFEF00D, b_dist,            '1, '0);
        drive(1'b0, 1'b1, 32'h0,        '1,                '1, '0);
        // Lane mask (all lanes written when the mask feature is absent).
        drive(1'b1, 1'b1, 32'h0,        b_ramp,            6'b101010, exp_mask);
        drive(1'b1, 1'b1, 32'h0,        b_dist,            '1, b_dist);
        drive(1'b0, 1'b0, 32'h0,        '0,                '1, '0);

        // Asynchronous reset between edges clears C at once.
        @(negedge clk);
        #2;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("async_reset_c", C, '0);
        check("async_reset_valid", {{(VEC_W-1){1'b0}}, out_valid}, '0);
        model_c = '0;
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        drive(1'b1, 1'b0, 32'h00000001, b_dist, '1, {6{32'h00000001}});
        drive(1'b0, 1'b1, 32'hFFFFFFFF, '1,     '1, '0);
        repeat (3) @(negedge clk);

        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d pending results expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no finish expected finish within 20000 time units");
        $fatal(1);
    end

endmodule
